// File: rtl/hvac_sequencer.sv
// Heat/cool demand sequencer: hysteresis thresholds, minimum run time, dead-time lockout.
// Optional sensor fault monitor compiled in with `define HVAC_SEQ_FAULT_EN.
module hvac_sequencer #(
  parameter int unsigned HYST      = 2,
  parameter int unsigned MIN_ON    = 8,
  parameter int unsigned DEAD_TIME = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [4:0] temperature,
  input  logic [4:0] desired_temperature,
  output logic       heating,
  output logic       cooling,
  output logic [1:0] state,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [1:0] {IDLE, HEAT, COOL, DEAD} fsm_e;

  localparam logic [5:0] HYST6       = 6'(HYST);
  localparam logic [7:0] MIN_ON_M1   = 8'(MIN_ON - 1);
  localparam logic [7:0] DEAD_LAST   = 8'(DEAD_TIME - 1);
  localparam logic [5:0] TEMP_MAX    = 6'd31;

  fsm_e       fsm_q, fsm_d;
  logic [7:0] run_cnt_q, run_cnt_d;
  logic [7:0] dead_cnt_q, dead_cnt_d;
  logic       heating_q, heating_d;
  logic       cooling_q, cooling_d;
  logic       busy_q, busy_d;
  logic       fault_act;

  logic [5:0] temp6, set6, sum6, lo6, hi6;

  always_comb begin
    temp6 = {1'b0, temperature};
    set6  = {1'b0, desired_temperature};
    sum6  = set6 + HYST6;
    lo6   = (set6 > HYST6) ? (set6 - HYST6) : '0;
    hi6   = (sum6 > TEMP_MAX) ? TEMP_MAX : sum6;
  end

`ifdef HVAC_SEQ_FAULT_EN
  logic [1:0] ext_cnt_q, ext_cnt_d;
  logic       fault_q, fault_d;
  logic       extreme;

  // ext_cnt holds the number of previous consecutive rail readings (saturating at 3)
  always_comb begin
    extreme   = (temperature == 5'd0) || (temperature == 5'd31);
    ext_cnt_d = '0;
    if (extreme)
      ext_cnt_d = (ext_cnt_q == 2'd3) ? 2'd3 : ext_cnt_q + 2'd1;
    fault_d = fault_q | (extreme && (ext_cnt_q >= 2'd2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_cnt_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      ext_cnt_q <= ext_cnt_d;
      fault_q   <= fault_d;
    end
  end

  assign fault_act = fault_q;
`else
  assign fault_act = 1'b0;
`endif

  always_comb begin
    fsm_d      = fsm_q;
    run_cnt_d  = run_cnt_q;
    dead_cnt_d = dead_cnt_q;
    unique case (fsm_q)
      IDLE: begin
        if (enable && !fault_act) begin
          if (temp6 <= lo6) begin
            fsm_d     = HEAT;
            run_cnt_d = '0;
          end else if (temp6 >= hi6) begin
            fsm_d     = COOL;
            run_cnt_d = '0;
          end
        end
      end
      HEAT, COOL: begin
        if (!enable || fault_act ||
            (run_cnt_q >= MIN_ON_M1 &&
             ((fsm_q == HEAT) ? (temp6 >= set6) : (temp6 <= set6)))) begin
          fsm_d      = DEAD;
          dead_cnt_d = '0;
        end else if (run_cnt_q != 8'hFF) begin
          run_cnt_d = run_cnt_q + 8'd1;
        end
      end
      DEAD: begin
        if (dead_cnt_q >= DEAD_LAST)
          fsm_d = IDLE;
        else
          dead_cnt_d = dead_cnt_q + 8'd1;
      end
      default: fsm_d = IDLE;
    endcase

    // Drives are flopped from the next state so they switch on the same edge as the FSM
    heating_d = (fsm_d == HEAT);
    cooling_d = (fsm_d == COOL);
    busy_d    = (fsm_d == DEAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= IDLE;
      run_cnt_q  <= '0;
      dead_cnt_q <= '0;
      heating_q  <= 1'b0;
      cooling_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      run_cnt_q  <= run_cnt_d;
      dead_cnt_q <= dead_cnt_d;
      heating_q  <= heating_d;
      cooling_q  <= cooling_d;
      busy_q     <= busy_d;
    end
  end

  assign heating = heating_q;
  assign cooling = cooling_q;
  assign state   = {heating_q, cooling_q};
  assign busy    = busy_q;
  assign fault   = fault_act;

endmodule
